// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB/BRANCH for the 16-bit datapath.
// Optional macro CTRL_TRAP_EN: illegal decodes enter TRAP with a sticky `illegal`; otherwise they retire as NOPs.
module multicycle_ctrl #(
    parameter int unsigned ALU_W       = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      instruction,
    input  logic [4:0]       flags,
    input  logic             mem_ready,
    output logic             irEn,
    output logic             pcRegEn,
    output logic             srcRegEn,
    output logic             dstRegEn,
    output logic             immRegEn,
    output logic             resultRegEn,
    output logic             regFileEn,
    output logic             flagEn,
    output logic             signEn,
    output logic             aluSrcSel,
    output logic [1:0]       wbSel,
    output logic [1:0]       pcSel,
    output logic [ALU_W-1:0] aluControl,
    output logic             memread,
    output logic             memwrite,
    output logic [2:0]       state,
    output logic             mem_timeout,
    output logic             illegal
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        BRANCH  = 3'd5,
        TRAP    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        K_ILL, K_ALU, K_LOAD, K_STOR, K_JAL, K_JCOND, K_BCOND
    } kind_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_LSH = 4'd7;
    localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic [3:0] op, cond, ext, code;
    logic       arith_ok;
    logic [3:0] arith_op;
    kind_t      kind;
    logic [3:0] alu_op;
    logic       use_imm, sign_ext, is_lui, no_wb, set_flags;
    logic       fn, fz, ff, fl, fc;
    logic       cond_true;
    logic       unused_src;

    assign op         = instruction[15:12];
    assign cond       = instruction[11:8];
    assign ext        = instruction[7:4];
    assign unused_src = ^instruction[3:0];
    assign {fn, fz, ff, fl, fc} = flags;

    // R-type selects the ALU op from ext, I-type from the opcode itself; both share one code table.
    assign code = (op == 4'b0000) ? ext : op;

    always_comb begin
        arith_ok = 1'b1;
        arith_op = OP_ADD;
        case (code)
            4'b0101: arith_op = OP_ADD;
            4'b1001: arith_op = OP_SUB;
            4'b1011: arith_op = OP_CMP;
            4'b0001: arith_op = OP_AND;
            4'b0010: arith_op = OP_OR;
            4'b0011: arith_op = OP_XOR;
            4'b1101: arith_op = OP_MOV;
            default: arith_ok = 1'b0;
        endcase
    end

    // Instruction class decode; IR is stable for the whole instruction so every state reuses it.
    always_comb begin
        kind     = K_ILL;
        alu_op   = OP_ADD;
        use_imm  = 1'b0;
        sign_ext = 1'b0;
        is_lui   = 1'b0;
        case (op)
            4'b0000: begin
                if (arith_ok) begin
                    kind   = K_ALU;
                    alu_op = arith_op;
                end
            end
            4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001, 4'b1011, 4'b1101: begin
                kind     = K_ALU;
                alu_op   = arith_op;
                use_imm  = 1'b1;
                sign_ext = (op == 4'b0101) || (op == 4'b1001) || (op == 4'b1011);
            end
            4'b1111: begin
                kind    = K_ALU;
                alu_op  = OP_MOV;
                use_imm = 1'b1;
                is_lui  = 1'b1;
            end
            4'b1000: begin
                if (ext == 4'b0100) begin
                    kind   = K_ALU;
                    alu_op = OP_LSH;
                end else if (ext[3:1] == 3'b000) begin
                    kind    = K_ALU;
                    alu_op  = OP_LSH;
                    use_imm = 1'b1;
                end
            end
            4'b0100: begin
                case (ext)
                    4'b0000: kind = K_LOAD;
                    4'b0100: kind = K_STOR;
                    4'b1000: kind = K_JAL;
                    4'b1100: kind = K_JCOND;
                    default: kind = K_ILL;
                endcase
            end
            4'b1100: kind = K_BCOND;
            default: kind = K_ILL;
        endcase
    end

    assign no_wb     = (kind == K_ALU) && (alu_op == OP_CMP);
    assign set_flags = (kind == K_ALU) && (alu_op <= OP_CMP);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            4'b0000: cond_true = fz;
            4'b0001: cond_true = !fz;
            4'b0010: cond_true = fc;
            4'b0011: cond_true = !fc;
            4'b0100: cond_true = fl;
            4'b0101: cond_true = !fl;
            4'b0110: cond_true = fn;
            4'b0111: cond_true = !fn;
            4'b1000: cond_true = ff;
            4'b1001: cond_true = !ff;
            4'b1010: cond_true = !fl && !fz;
            4'b1011: cond_true = fl || fz;
            4'b1100: cond_true = !fn && !fz;
            4'b1101: cond_true = fn || fz;
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and per-state control outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        irEn        = 1'b0;
        pcRegEn     = 1'b0;
        srcRegEn    = 1'b0;
        dstRegEn    = 1'b0;
        immRegEn    = 1'b0;
        resultRegEn = 1'b0;
        regFileEn   = 1'b0;
        flagEn      = 1'b0;
        signEn      = 1'b0;
        aluSrcSel   = 1'b0;
        wbSel       = 2'd0;
        pcSel       = 2'd0;
        aluControl  = '0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        mem_timeout = 1'b0;
        case (state_q)
            FETCH: begin
                irEn    = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                case (kind)
                    K_ALU: begin
                        srcRegEn = !use_imm;
                        immRegEn = use_imm;
                        dstRegEn = 1'b1;
                        signEn   = sign_ext;
                        state_d  = EXECUTE;
                    end
                    K_LOAD, K_STOR: begin
                        srcRegEn = 1'b1;
                        dstRegEn = 1'b1;
                        state_d  = MEM;
                    end
                    K_JAL, K_JCOND: begin
                        srcRegEn = 1'b1;
                        state_d  = BRANCH;
                    end
                    K_BCOND: begin
                        immRegEn = 1'b1;
                        signEn   = 1'b1;
                        state_d  = BRANCH;
                    end
                    default: begin
`ifdef CTRL_TRAP_EN
                        state_d = TRAP;
`else
                        state_d = WB;
`endif
                    end
                endcase
            end
            EXECUTE: begin
                aluControl  = ALU_W'(alu_op);
                aluSrcSel   = use_imm;
                resultRegEn = 1'b1;
                state_d     = WB;
            end
            WB: begin
                pcRegEn = 1'b1;
                case (kind)
                    K_ALU: begin
                        regFileEn = !no_wb;
                        flagEn    = set_flags;
                        wbSel     = is_lui ? 2'd3 : 2'd0;
                    end
                    K_LOAD: begin
                        regFileEn = 1'b1;
                        wbSel     = 2'd1;
                    end
                    default: ;
                endcase
                state_d = FETCH;
            end
            MEM: begin
                memread  = (kind == K_LOAD);
                memwrite = (kind == K_STOR);
                if (mem_ready) begin
                    cnt_d = 8'd0;
                    if (kind == K_LOAD) begin
                        state_d = WB;
                    end else begin
                        pcRegEn = 1'b1;
                        state_d = FETCH;
                    end
                end else if (cnt_q == WAIT_MAX) begin
                    mem_timeout = 1'b1;
                    pcRegEn     = 1'b1;
                    cnt_d       = 8'd0;
                    state_d     = FETCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            BRANCH: begin
                pcRegEn = 1'b1;
                case (kind)
                    K_JAL: begin
                        regFileEn = 1'b1;
                        wbSel     = 2'd2;
                        pcSel     = 2'd2;
                    end
                    K_JCOND: pcSel = cond_true ? 2'd2 : 2'd0;
                    K_BCOND: pcSel = cond_true ? 2'd1 : 2'd0;
                    default: pcSel = 2'd0;
                endcase
                state_d = FETCH;
            end
            TRAP: begin
`ifdef CTRL_TRAP_EN
                state_d = TRAP;
`else
                state_d = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase
    end

    assign state = state_q;

`ifdef CTRL_TRAP_EN
    logic illegal_q;

    // Sticky until reset; set on the edge that enters TRAP.
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (state_d == TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into an expected per-cycle output trace
// from the instruction-set rules, then replayed against the DUT with random flags/mem_ready.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    localparam int unsigned ALU_W = 4;
    localparam int T = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      instruction;
    logic [4:0]       flags;
    logic             mem_ready;
    logic             irEn, pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn;
    logic             regFileEn, flagEn, signEn, aluSrcSel;
    logic [1:0]       wbSel, pcSel;
    logic [ALU_W-1:0] aluControl;
    logic             memread, memwrite, mem_timeout, illegal;
    logic [2:0]       state;

    multicycle_ctrl #(.ALU_W(ALU_W), .MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .flags(flags),
        .mem_ready(mem_ready), .irEn(irEn), .pcRegEn(pcRegEn), .srcRegEn(srcRegEn),
        .dstRegEn(dstRegEn), .immRegEn(immRegEn), .resultRegEn(resultRegEn),
        .regFileEn(regFileEn), .flagEn(flagEn), .signEn(signEn), .aluSrcSel(aluSrcSel),
        .wbSel(wbSel), .pcSel(pcSel), .aluControl(aluControl), .memread(memread),
        .memwrite(memwrite), .state(state), .mem_timeout(mem_timeout), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic ir, pc, src, dst, imm, res, rf, fl, sg, asel;
        logic [1:0] wb;
        logic [1:0] pcs;
        logic [3:0] alu;
        logic mr, mw, to, ill;
    } obs_t;

    typedef struct {
        obs_t exp;
        logic is_mem;
        logic ready;
    } step_t;

    obs_t  act;
    assign act = {state, irEn, pcRegEn, srcRegEn, dstRegEn, immRegEn, resultRegEn, regFileEn,
                  flagEn, signEn, aluSrcSel, wbSel, pcSel, 4'(aluControl),
                  memread, memwrite, mem_timeout, illegal};

    int    total = 0;
    int    fails = 0;
    step_t trace[$];
    bit    last_illegal;

    function automatic void push(input obs_t o, input logic is_mem, input logic rdy);
        step_t s;
        s.exp = o; s.is_mem = is_mem; s.ready = rdy;
        trace.push_back(s);
    endfunction

    function automatic void arith(input logic [3:0] c, output logic ok, output logic [3:0] alu);
        ok = 1'b1; alu = 4'd0;
        case (c)
            4'b0101: alu = 4'd0;
            4'b1001: alu = 4'd1;
            4'b1011: alu = 4'd2;
            4'b0001: alu = 4'd3;
            4'b0010: alu = 4'd4;
            4'b0011: alu = 4'd5;
            4'b1101: alu = 4'd6;
            default: ok = 1'b0;
        endcase
    endfunction

    function automatic logic cond_met(input logic [3:0] c, input logic [4:0] f);
        logic n, z, fz, l, cy;
        {n, z, fz, l, cy} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return l;
            4'd5:  return !l;
            4'd6:  return n;
            4'd7:  return !n;
            4'd8:  return fz;
            4'd9:  return !fz;
            4'd10: return !l && !z;
            4'd11: return l || z;
            4'd12: return !n && !z;
            4'd13: return n || z;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    localparam int C_ILL = 0, C_RALU = 1, C_IALU = 2, C_LUI = 3, C_LSH = 4, C_LSHI = 5;
    localparam int C_LOAD = 6, C_STOR = 7, C_JAL = 8, C_JCOND = 9, C_BCOND = 10;

    // Expected cycle-by-cycle outputs for one instruction; w = cycles mem_ready stays low.
    function automatic void build(input logic [15:0] ins, input logic [4:0] f, input int w);
        logic [3:0] op, cf, ext, alu;
        logic ok;
        int cls;
        obs_t o;
        op = ins[15:12]; cf = ins[11:8]; ext = ins[7:4];
        arith((op == 4'h0) ? ext : op, ok, alu);
        if (op == 4'h0 && ok) cls = C_RALU;
        else if (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD}) cls = C_IALU;
        else if (op == 4'hF) cls = C_LUI;
        else if (op == 4'h8 && ext == 4'h4) cls = C_LSH;
        else if (op == 4'h8 && ext[3:1] == 3'b000) cls = C_LSHI;
        else if (op == 4'h4 && ext == 4'h0) cls = C_LOAD;
        else if (op == 4'h4 && ext == 4'h4) cls = C_STOR;
        else if (op == 4'h4 && ext == 4'h8) cls = C_JAL;
        else if (op == 4'h4 && ext == 4'hC) cls = C_JCOND;
        else if (op == 4'hC) cls = C_BCOND;
        else cls = C_ILL;
        last_illegal = (cls == C_ILL);
        trace.delete();

        o = '0; o.ir = 1'b1; push(o, 1'b0, 1'b0);

        o = '0; o.st = 3'd1;
        case (cls)
            C_RALU, C_LSH, C_LOAD, C_STOR: begin o.src = 1'b1; o.dst = 1'b1; end
            C_IALU: begin o.imm = 1'b1; o.dst = 1'b1; o.sg = (op inside {4'h5, 4'h9, 4'hB}); end
            C_LUI, C_LSHI: begin o.imm = 1'b1; o.dst = 1'b1; end
            C_JAL, C_JCOND: o.src = 1'b1;
            C_BCOND: begin o.imm = 1'b1; o.sg = 1'b1; end
            default: ;
        endcase
        push(o, 1'b0, 1'b0);

        case (cls)
            C_RALU, C_IALU, C_LUI, C_LSH, C_LSHI: begin
                o = '0; o.st = 3'd2; o.res = 1'b1;
                o.alu = (cls == C_LUI) ? 4'd6 : (cls == C_LSH || cls == C_LSHI) ? 4'd7 : alu;
                o.asel = (cls == C_IALU || cls == C_LUI || cls == C_LSHI);
                push(o, 1'b0, 1'b0);
                o = '0; o.st = 3'd4; o.pc = 1'b1;
                o.rf = !((cls == C_RALU || cls == C_IALU) && alu == 4'd2);
                o.fl = (cls == C_RALU || cls == C_IALU) && (alu <= 4'd2);
                o.wb = (cls == C_LUI) ? 2'd3 : 2'd0;
                push(o, 1'b0, 1'b0);
            end
            C_LOAD, C_STOR: begin
                for (int k = 0; k <= T; k++) begin
                    o = '0; o.st = 3'd3; o.mr = (cls == C_LOAD); o.mw = (cls == C_STOR);
                    if (k == w) begin
                        o.pc = (cls == C_STOR);
                        push(o, 1'b1, 1'b1);
                        if (cls == C_LOAD) begin
                            o = '0; o.st = 3'd4; o.pc = 1'b1; o.rf = 1'b1; o.wb = 2'd1;
                            push(o, 1'b0, 1'b0);
                        end
                        break;
                    end
                    if (k == T) begin
                        o.to = 1'b1; o.pc = 1'b1;
                        push(o, 1'b1, 1'b0);
                        break;
                    end
                    push(o, 1'b1, 1'b0);
                end
            end
            C_JAL, C_JCOND, C_BCOND: begin
                o = '0; o.st = 3'd5; o.pc = 1'b1;
                if (cls == C_JAL) begin o.rf = 1'b1; o.wb = 2'd2; o.pcs = 2'd2; end
                else if (cond_met(cf, f)) o.pcs = (cls == C_JCOND) ? 2'd2 : 2'd1;
                push(o, 1'b0, 1'b0);
            end
            default: begin
`ifdef CTRL_TRAP_EN
                o = '0; o.st = 3'd6; o.ill = 1'b1;
                for (int k = 0; k < 4; k++) push(o, 1'b0, 1'b0);
`else
                o = '0; o.st = 3'd4; o.pc = 1'b1;
                push(o, 1'b0, 1'b0);
`endif
            end
        endcase
    endfunction

    // Entered and left just after a rising edge with the DUT in FETCH.
    task automatic run_instr(input string name, input logic [15:0] ins, input logic [4:0] f,
                             input int w, input int max_steps);
        obs_t a;
        build(ins, f, w);
        instruction = ins;
        flags = f;
        for (int i = 0; i < trace.size() && i < max_steps; i++) begin
            mem_ready = trace[i].is_mem ? trace[i].ready : 1'($urandom_range(0, 1));
            @(negedge clk);
            total++;
            if (act !== trace[i].exp) begin
                fails++;
                $display("FAIL %s ins=%h step %0d: got %h expected %h", name, ins, i, act, trace[i].exp);
            end
            @(posedge clk); #1;
        end
`ifdef CTRL_TRAP_EN
        if (last_illegal && max_steps >= trace.size()) begin
            reset = 1'b1;
            @(posedge clk); #1;
            @(negedge clk);
            a = act; a.ir = 1'b0;
            total++;
            if (a !== '0) begin
                fails++;
                $display("FAIL %s trap_reset: got %h expected %h (irEn ignored)", name, a, obs_t'(0));
            end
            @(posedge clk); #1;
            reset = 1'b0;
        end
`endif
    endtask

    task automatic test_reset();
        obs_t a;
        reset = 1'b1; mem_ready = 1'b1; instruction = 16'h4102; flags = 5'h1F;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a = act; a.ir = 1'b0;
            total++;
            if (a !== '0) begin
                fails++;
                $display("FAIL reset_state cycle %0d: got %h expected %h (irEn ignored)", i, a, obs_t'(0));
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_alu();
        run_instr("add_r1_r2", 16'h0152, 5'h00, 0, 99);
        run_instr("cmpi", 16'hB1FF, 5'h1F, 0, 99);
        run_instr("lui", 16'hF3A5, 5'h00, 0, 99);
        run_instr("lsh", 16'h8142, 5'h00, 0, 99);
        run_instr("lshi", 16'h8213, 5'h00, 0, 99);
        run_instr("subi", 16'h9407, 5'h00, 0, 99);
        run_instr("movi", 16'hD2C1, 5'h00, 0, 99);
        run_instr("xor", 16'h0332, 5'h00, 0, 99);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", 16'hC005, 5'b01000, 0, 99);
        run_instr("beq_not", 16'hC005, 5'b10111, 0, 99);
        run_instr("b_never", 16'hCF05, 5'h1F, 0, 99);
        run_instr("b_never0", 16'hCF05, 5'h00, 0, 99);
        for (int c = 0; c < 16; c++) begin
            run_instr("jcond", {4'h4, 4'(c), 4'hC, 4'h3}, 5'($urandom), 0, 99);
            run_instr("bcond", {4'hC, 4'(c), 8'($urandom)}, 5'($urandom), 0, 99);
        end
    endtask

    task automatic test_jal();
        run_instr("jal", 16'h4183, 5'h00, 0, 99);
        run_instr("jal_flags", 16'h4F83, 5'h1F, 0, 99);
    endtask

    task automatic test_mem();
        run_instr("load_w3", 16'h4102, 5'h00, 3, 99);
        run_instr("load_w0", 16'h4102, 5'h00, 0, 99);
        run_instr("load_wmax", 16'h4102, 5'h00, T, 99);
        run_instr("load_timeout", 16'h4102, 5'h00, 1000, 99);
        run_instr("stor_w0", 16'h4145, 5'h00, 0, 99);
        run_instr("stor_w5", 16'h4145, 5'h00, 5, 99);
        run_instr("stor_timeout", 16'h4145, 5'h00, T + 1, 99);
    endtask

    task automatic test_reset_mid_mem();
        obs_t a, e;
        for (int v = 0; v < 2; v++) begin
            run_instr("rst_mem_pre", (v == 0) ? 16'h4102 : 16'h4145, 5'h00, 1000, 3);
            mem_ready = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            e = '0; e.st = 3'd3; e.mr = (v == 0); e.mw = (v == 1);
            total++;
            if (act !== e) begin
                fails++;
                $display("FAIL rst_mem_hold v%0d: got %h expected %h", v, act, e);
            end
            @(posedge clk); #1;
            @(negedge clk);
            a = act; a.ir = 1'b0;
            total++;
            if (a !== '0) begin
                fails++;
                $display("FAIL rst_mem_drop v%0d: got %h expected %h (irEn ignored)", v, a, obs_t'(0));
            end
            @(posedge clk); #1;
            reset = 1'b0;
        end
    endtask

    task automatic test_illegal();
        run_instr("illegal_7000", 16'h7000, 5'h00, 0, 99);
        run_instr("illegal_ext", 16'h4120, 5'h00, 0, 99);
        run_instr("after_illegal", 16'h0152, 5'h00, 0, 99);
    endtask

    task automatic test_back_to_back();
        logic [3:0] iops [9];
        logic [3:0] rext [7];
        logic [3:0] sext [7];
        logic [15:0] ins;
        iops = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF, 4'hC};
        rext = '{4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
        sext = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h4, 4'h0, 4'h1};
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: ins = 16'($urandom);
                1: ins = {iops[$urandom_range(0, 8)], 12'($urandom)};
                2: ins = {4'h0, 4'($urandom), rext[$urandom_range(0, 6)], 4'($urandom)};
                default: begin
                    int k;
                    k = $urandom_range(0, 6);
                    ins = {(k < 4) ? 4'h4 : 4'h8, 4'($urandom), sext[k], 4'($urandom)};
                end
            endcase
            run_instr("random", ins, 5'($urandom), $urandom_range(0, T + 2), 99);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", total, fails + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        instruction = 16'h0000;
        flags = 5'h00;
        mem_ready = 1'b0;
        test_reset();
        test_alu();
        test_branch();
        test_jal();
        test_mem();
        test_reset_mid_mem();
        test_illegal();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", total, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle control unit for the 16-bit processor datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath register enable, mux select and ALU opcode. It adds condition-code evaluation for Bcond/Jcond, a `mem_ready` handshake with timeout, and an optional illegal-opcode trap.

## Interface
- `ALU_W`, 4: width of `aluControl`.
- `MEM_TIMEOUT`, 15: maximum MEM-state wait cycles before abort; legal range 1–255.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high; sampled on `posedge clk` only.
- `instruction` in 16: current IR contents; [15:12] op, [11:8] dst/cond, [7:4] ext, [3:0] src.
- `flags` in 5: {N,Z,F,L,C} from the flag register.
- `mem_ready` in 1: memory completes the current access this cycle.
- `irEn`, `pcRegEn`, `srcRegEn`, `dstRegEn`, `immRegEn`, `resultRegEn`, `regFileEn`, `flagEn`, `signEn` out 1 each: register/load enables.
- `aluSrcSel` out 1: 0 = src reg, 1 = imm reg.
- `wbSel` out 2: 0 ALU result, 1 memory data, 2 PC+1 (link), 3 imm<<8 (LUI).
- `pcSel` out 2: 0 PC+1, 1 PC+sign-extended disp, 2 src reg.
- `aluControl` out ALU_W: ADD 0, SUB 1, CMP 2, AND 3, OR 4, XOR 5, MOV 6, LSH 7.
- `memread`, `memwrite` out 1: data-memory strobes.
- `state` out 3: current state encoding.
- `mem_timeout` out 1: one-cycle pulse on an aborted access.
- `illegal` out 1: sticky trap indicator; only when CTRL_TRAP_EN is defined, otherwise tied 0.

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, BRANCH=5, TRAP=6.
- Any output not listed for a state is 0.
- FETCH: `irEn`=1; next state is DECODE.
- DECODE: decodes `instruction` and routes as follows.
  - R-type (op 0000): ext ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011, MOV 1101. Asserts `srcRegEn`, `dstRegEn`; next state EXECUTE.
  - I-type: op ANDI 0001, ORI 0010, XORI 0011, ADDI 0101, SUBI 1001, CMPI 1011, MOVI 1101, LUI 1111. Asserts `immRegEn`, `dstRegEn`. `signEn`=1 for ADDI/SUBI/CMPI. Next state EXECUTE.
  - Shift (op 1000): LSH ext 0100, LSHI ext 000x. Next state EXECUTE with `aluControl`=LSH; LSHI uses `aluSrcSel`=1.
  - Special (op 0100): LOAD ext 0000 and STOR ext 0100 assert `srcRegEn`, `dstRegEn`; next state MEM. JAL 1000 and Jcond 1100 go to BRANCH.
  - Bcond (op 1100): `immRegEn`=1, `signEn`=1; next state BRANCH.
  - Other encodings are illegal; see Configuration.
- EXECUTE: drives `aluControl` and `aluSrcSel`; `resultRegEn`=1; next state WB.
- WB: `pcRegEn`=1, `pcSel`=0.
  - `regFileEn`=1 except for CMP/CMPI.
  - `flagEn`=1 for ADD/SUB/CMP and their immediates.
  - `wbSel`=3 for LUI, 1 after LOAD, else 0.
  - Next state FETCH.
- MEM: `memread` (LOAD) or `memwrite` (STOR) held high with an 8-bit wait counter.
  - If `mem_ready`=1: LOAD goes to WB. STOR asserts `pcRegEn` and goes to FETCH.
  - If the counter equals MEM_TIMEOUT with `mem_ready`=0: pulse `mem_timeout`, assert `pcRegEn` (instruction skipped, no write-back), go to FETCH.
- BRANCH: evaluates the condition on [11:8] and `flags`:
  - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; HI 0100 L; LS 0101 !L; GT 0110 N; LE 0111 !N; FS 1000 F; FC 1001 !F; LO 1010 !L&!Z; HS 1011 L|Z; LT 1100 !N&!Z; GE 1101 N|Z; UC 1110 always; 1111 never.
  - `pcRegEn`=1. `pcSel` is 1 (Bcond taken) or 2 (Jcond taken or JAL), else 0.
  - JAL additionally sets `regFileEn`=1 and `wbSel`=2, and is unconditional.
  - Next state FETCH.

## Timing
- Reset: `state`=FETCH, wait counter=0, `illegal`=0; all outputs 0 except FETCH's `irEn`=1 in the cycle after reset deasserts.
- Reset has priority over everything. Reset mid-MEM drops `memread`/`memwrite` on the next edge, with no `pcRegEn`.
- Latencies (cycles per instruction, FETCH to next FETCH):
  - ALU/shift/immediate: 4.
  - Branch/jump: 3.
  - STOR: 3 + w; LOAD: 4 + w. w = cycles `mem_ready` stays low, with w ≤ MEM_TIMEOUT.
- `mem_ready` is sampled only in MEM and ignored elsewhere.
- `mem_ready` arriving in the same cycle the counter hits MEM_TIMEOUT is treated as success; no timeout.
- The wait counter clears on every MEM exit.
- `flags` is sampled combinationally in BRANCH, so the flags written in a preceding WB are visible.

## Configuration
- `CTRL_TRAP_EN` defined: an illegal decode goes to TRAP. TRAP holds with all enables 0 and `illegal`=1 until `reset`.
- `CTRL_TRAP_EN` undefined: an illegal decode goes to WB as a NOP. `pcRegEn`=1, no `regFileEn`/`flagEn`; the instruction takes 3 cycles. `illegal` is constant 0.

## Test plan
- ADD r1,r2 (0x0152) from reset: state sequence 0,1,2,4,0. EXECUTE has `aluControl`=0 and `resultRegEn`=1. WB has `regFileEn`=1 and `flagEn`=1.
- CMPI (0xB1FF): DECODE has `signEn`=1. WB has `flagEn`=1, `regFileEn`=0, `pcRegEn`=1.
- Bcond EQ (0xC005):
  - With Z=1: BRANCH has `pcSel`=1, `pcRegEn`=1.
  - With Z=0: `pcSel`=0.
  - Cond 1111 is never taken.
- LOAD (0x4102) with `mem_ready` low 3 cycles: `memread` high 4 cycles, then WB with `wbSel`=1. With `mem_ready` never high: `mem_timeout` pulses after 15 wait cycles and no `regFileEn` is asserted.
- JAL (0x4183): BRANCH has `regFileEn`=1, `wbSel`=2, `pcSel`=2.
- Opcode 0x7000:
  - With CTRL_TRAP_EN: TRAP with `illegal`=1 held.
  - Without: NOP with 3-cycle `pcRegEn`.
  - `reset` asserted during MEM returns to FETCH next edge with strobes 0.
